dds_multichannel: RTL and testbench
===================================

Name: dds_multichannel

Overview:
N-channel DDS synthesizer. Each channel has its own phase step, phase offset, amplitude and waveform.
- Configuration is written through a valid/ready register port into shadow registers.
- A single commit pulse moves all shadow registers into active registers at once, so channels change together in the same cycle.
- The block sits between the host control interface and the per-channel DAC formatters; it generalises the single-channel DDS core.

Parameters:
NUM_CH, 4, number of independent channels
PHASE_W, 32, phase accumulator width
LUT_W, 10, quarter-sine LUT address width (2^LUT_W entries)
OUT_W, 14, signed output sample width per channel
AMP_W, 8, amplitude fraction bits; 2^AMP_W means unity gain

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
cfg_valid  in  1  config write request
cfg_ready  out  1  config write accepted when high together with cfg_valid
cfg_ch  in  max(1,$clog2(NUM_CH))  target channel
cfg_addr  in  2  register select: 0 step, 1 offset, 2 amp, 3 wave_sel
cfg_data  in  PHASE_W  write data, LSB-aligned
commit  in  1  pulse: copy all shadow registers to active registers
sync_clr  in  1  pulse: zero all phase accumulators
out_valid  out  1  dds_out holds valid samples
dds_out  out  NUM_CH*OUT_W  channel i occupies bits [i*OUT_W +: OUT_W], signed
wrap  out  NUM_CH  per-channel accumulator-overflow pulse, pipeline-aligned

Behaviour:
- Reset values:
  - acc, step, offset: 0.
  - amp: 2^AMP_W (unity).
  - wave_sel: 0.
  - Shadow registers equal active registers.
  - dds_out, wrap, out_valid: 0.
  - cfg_ready: 0 during rst, 1 from the first cycle after rst.
- Config write: occurs when cfg_valid && cfg_ready.
  - Writes the shadow register only; active registers are unchanged.
  - cfg_ch >= NUM_CH: write is accepted and discarded.
  - amp: value is cfg_data[AMP_W:0]; values above 2^AMP_W clamp to 2^AMP_W.
  - wave_sel: value is cfg_data[1:0].
- cfg_ready is 0 in any cycle where commit=1. A write and a commit can never coincide.
- Commit: the active registers of all channels take the shadow values at the clock edge where commit=1. The new step is used from the next accumulation.
- Accumulator update priority: rst > sync_clr > normal.
  - Normal: acc <= acc + step, mod 2^PHASE_W.
  - sync_clr together with commit: acc <= 0 and the registers commit; both take effect.
- Effective phase: p = acc + offset, mod 2^PHASE_W.
  - MSB = p[PHASE_W-1].
  - u = p[PHASE_W-2 -: OUT_W], unsigned.
  - t = p[PHASE_W-1 -: OUT_W].
- Waveforms:
  - 0 sine: quadrant = p[top 2 bits]; LUT address = p[PHASE_W-3 -: LUT_W], bitwise-inverted in quadrants 1 and 3; result negated in quadrants 2 and 3. Uses the existing quarter_sine_lut (1-cycle registered read).
  - 1 square: MSB ? -2^(OUT_W-1) : 2^(OUT_W-1)-1.
  - 2 saw: t - 2^(OUT_W-1).
  - 3 triangle: MSB ? (2^(OUT_W-1)-1 - u) : (u - 2^(OUT_W-1)).
  - All arithmetic is OUT_W-bit two's complement.
- Amplitude: y = (w * amp) >>> AMP_W, signed arithmetic shift (floor). No saturation is needed because amp <= unity.
- Pipeline, latency 3 clocks from the acc register to dds_out:
  - S1: LUT read; register non-sine waveforms and the sign.
  - S2: negate and select.
  - S3: multiply and output register.
- wrap[i]: 1 for one cycle, aligned with the dds_out sample computed from the first post-overflow acc value. sync_clr does not generate wrap.
- out_valid: rises 3 cycles after rst deasserts and stays high until the next rst.
- Reset mid-operation clears everything, including pipeline contents, in 1 cycle.

Optional Feature:
DDS_MULTICHANNEL_DITHER_EN
- Defined:
  - Each channel has a 16-bit Galois LFSR (x^16+x^14+x^13+x^11+1) with seed 16'hACE1 XOR i. It steps every cycle and resets to its seed.
  - Its low min(16, PHASE_W-2-LUT_W) bits are added to p before LUT addressing, for sine only.
  - Sine samples may differ by ±1 LUT step.
- Undefined: no LFSR logic; output is bit-exact to the formulas above.
- All tests below run without the macro.

Test Plan:
- Reset: hold rst 5 cycles, release -> dds_out=0, wrap=0, out_valid=0 for 3 cycles, then out_valid=1; cfg_ready=1 from the first cycle after rst.
- Square: ch0 step=0x4000_0000, wave=1, commit+sync_clr -> ch0 repeats 8191, 8191, -8192, -8192; wrap[0] pulses every 4th sample, aligned with the first 8191.
- Saw: ch1 step=0x0100_0000, offset=0x8000_0000, wave=2, commit+sync_clr -> ch1 first sample 0, then +64 per cycle; other channels stay 0.
- Amplitude: square ch0 with amp=128 -> 4095/-4096; amp write 300 -> reads as unity, output 8191/-8192.
- Shadow/commit: write ch2 step without commit -> ch2 output unchanged for 20 cycles; cfg_valid held during the commit cycle -> cfg_ready=0, write accepted the next cycle.
- Sine quadrants: ch3 step=0x4000_0000, wave=0 -> samples LUT[0], LUT[1023], -LUT[0], -LUT[1023], repeating.

Source files
------------

// File: rtl/dds_multichannel_if.sv
// Host config and sample bus for dds_multichannel: master is the host/formatter side, slave is the synthesizer.
interface dds_multichannel_if #(
  parameter int NUM_CH  = 4,
  parameter int PHASE_W = 32,
  parameter int OUT_W   = 14
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic                      cfg_valid;
  logic                      cfg_ready;
  logic [CH_W-1:0]           cfg_ch;
  logic [1:0]                cfg_addr;
  logic [PHASE_W-1:0]        cfg_data;
  logic                      commit;
  logic                      sync_clr;
  logic                      out_valid;
  logic [NUM_CH*OUT_W-1:0]   dds_out;
  logic [NUM_CH-1:0]         wrap;

  modport master (
    output cfg_valid, cfg_ch, cfg_addr, cfg_data, commit, sync_clr,
    input  cfg_ready, out_valid, dds_out, wrap
  );

  modport slave (
    input  cfg_valid, cfg_ch, cfg_addr, cfg_data, commit, sync_clr,
    output cfg_ready, out_valid, dds_out, wrap
  );
endinterface

// File: rtl/dds_multichannel.sv
// N-channel DDS with shadow/commit config, 3-cycle acc-to-dds_out latency; no output backpressure,
// cfg_ready drops only in reset and commit cycles. Optional LUT dither: DDS_MULTICHANNEL_DITHER_EN.

// Quarter-sine ROM, 1-cycle registered read; entry k = round((2^(OUT_W-1)-1) * sin(pi/2 * k / 2^LUT_W)).
module quarter_sine_lut #(
  parameter int LUT_W = 10,
  parameter int OUT_W = 14
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [LUT_W-1:0] addr_i,
  output logic [OUT_W-2:0] dat_o
);
  localparam longint HALF_PI_Q30 = 64'sd1686629713;

  // Q30 Taylor series to x^9; error stays far below half an output LSB.
  function automatic logic [OUT_W-2:0] entry(input int k);
    longint x, x2, term, sum, fs;
    fs   = (64'sd1 <<< (OUT_W-1)) - 64'sd1;
    x    = (HALF_PI_Q30 * longint'(k)) >>> LUT_W;
    x2   = (x * x) >>> 30;
    term = x;
    sum  = x;
    for (int n = 1; n <= 4; n++) begin
      term = -((term * x2) >>> 30) / longint'((2*n) * (2*n + 1));
      sum  = sum + term;
    end
    return (OUT_W-1)'((sum * fs + (64'sd1 <<< 29)) >>> 30);
  endfunction

  logic [OUT_W-2:0] rom [2**LUT_W];

  for (genvar k = 0; k < 2**LUT_W; k++) begin : g_rom
    assign rom[k] = entry(k);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) dat_o <= '0;
    else       dat_o <= rom[addr_i];
  end
endmodule

module dds_multichannel #(
  parameter int NUM_CH  = 4,
  parameter int PHASE_W = 32,
  parameter int LUT_W   = 10,
  parameter int OUT_W   = 14,
  parameter int AMP_W   = 8
) (
  input logic               clk,
  input logic               rst,
  dds_multichannel_if.slave bus
);
  localparam logic [AMP_W:0]   AMP_ONE = {1'b1, {AMP_W{1'b0}}};
  localparam logic [OUT_W-1:0] HALF    = {1'b1, {(OUT_W-1){1'b0}}};
  localparam logic [OUT_W-1:0] POS_FS  = ~HALF;
  localparam int               PW      = OUT_W + AMP_W + 2;

  logic [PHASE_W-1:0] step_q [NUM_CH], sh_step_q [NUM_CH];
  logic [PHASE_W-1:0] off_q [NUM_CH], sh_off_q [NUM_CH];
  logic [AMP_W:0]     amp_q [NUM_CH], sh_amp_q [NUM_CH];
  logic [1:0]         wave_q [NUM_CH], sh_wave_q [NUM_CH];
  logic [PHASE_W-1:0] acc_q [NUM_CH], acc_d [NUM_CH];
  logic [PHASE_W-1:0] p [NUM_CH], p_s [NUM_CH];
  logic [NUM_CH-1:0]  carry, wrap0_q, wrap1_q, wrap2_q, wrap3_q;
  logic               rdy_q, cfg_fire;
  logic [2:0]         vld_q;
  logic [AMP_W:0]     amp_wr;

  logic [LUT_W-1:0]        lut_addr [NUM_CH];
  logic [OUT_W-2:0]        lut_dat [NUM_CH];
  logic [OUT_W-1:0]        ns_d [NUM_CH], ns1_q [NUM_CH];
  logic [NUM_CH-1:0]       sine1_q, neg1_q;
  logic [AMP_W:0]          amp1_q [NUM_CH], amp2_q [NUM_CH];
  logic signed [OUT_W-1:0] s2_q [NUM_CH];
  logic signed [PW-1:0]    prod [NUM_CH];
  logic [NUM_CH-1:0][OUT_W-1:0] out_q;
  logic                    unused_ok;

  assign bus.cfg_ready = rdy_q & ~bus.commit;
  assign cfg_fire      = bus.cfg_valid & bus.cfg_ready;
  assign bus.out_valid = vld_q[2];
  assign bus.dds_out   = out_q;
  assign bus.wrap      = wrap3_q;

`ifdef DDS_MULTICHANNEL_DITHER_EN
  localparam int DW = (PHASE_W - 2 - LUT_W < 16) ? (PHASE_W - 2 - LUT_W) : 16;
  logic [15:0] lfsr_q [NUM_CH];

  // Galois form of x^16+x^14+x^13+x^11+1, shifting right.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (rst) lfsr_q[i] <= 16'hACE1 ^ 16'(i);
      else     lfsr_q[i] <= {1'b0, lfsr_q[i][15:1]} ^ (lfsr_q[i][0] ? 16'hB400 : 16'h0000);
    end
  end
`endif

  always_comb begin
    amp_wr    = (bus.cfg_data[AMP_W:0] > AMP_ONE) ? AMP_ONE : bus.cfg_data[AMP_W:0];
    carry     = '0;
    unused_ok = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      {carry[i], acc_d[i]} = {1'b0, acc_q[i]} + {1'b0, step_q[i]};
      p[i] = acc_q[i] + off_q[i];
`ifdef DDS_MULTICHANNEL_DITHER_EN
      p_s[i]    = p[i] + PHASE_W'(lfsr_q[i][DW-1:0]);
      unused_ok = unused_ok ^ (^lfsr_q[i]);
`else
      p_s[i] = p[i];
`endif
      lut_addr[i] = p_s[i][PHASE_W-3 -: LUT_W] ^ {LUT_W{p_s[i][PHASE_W-2]}};
      case (wave_q[i])
        2'd1:    ns_d[i] = p[i][PHASE_W-1] ? HALF : POS_FS;
        2'd2:    ns_d[i] = p[i][PHASE_W-1 -: OUT_W] - HALF;
        default: ns_d[i] = p[i][PHASE_W-1] ? (POS_FS - p[i][PHASE_W-2 -: OUT_W])
                                           : (p[i][PHASE_W-2 -: OUT_W] - HALF);
      endcase
      prod[i]   = PW'(s2_q[i]) * PW'($signed({1'b0, amp2_q[i]}));
      unused_ok = unused_ok ^ (^{p[i], p_s[i], prod[i]});
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_lut
    quarter_sine_lut #(.LUT_W(LUT_W), .OUT_W(OUT_W)) u_lut (
      .clk_i (clk),
      .rst_i (rst),
      .addr_i(lut_addr[i]),
      .dat_o (lut_dat[i])
    );
  end

  // Writes land in shadows only; commit swaps every channel on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdy_q   <= 1'b0;
      vld_q   <= '0;
      wrap0_q <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        step_q[i] <= '0;      sh_step_q[i] <= '0;
        off_q[i]  <= '0;      sh_off_q[i]  <= '0;
        amp_q[i]  <= AMP_ONE; sh_amp_q[i]  <= AMP_ONE;
        wave_q[i] <= '0;      sh_wave_q[i] <= '0;
        acc_q[i]  <= '0;
      end
    end else begin
      rdy_q <= 1'b1;
      vld_q <= {vld_q[1:0], 1'b1};
      for (int i = 0; i < NUM_CH; i++) begin
        if (cfg_fire && (32'(bus.cfg_ch) == i)) begin
          case (bus.cfg_addr)
            2'd0:    sh_step_q[i] <= bus.cfg_data;
            2'd1:    sh_off_q[i]  <= bus.cfg_data;
            2'd2:    sh_amp_q[i]  <= amp_wr;
            default: sh_wave_q[i] <= bus.cfg_data[1:0];
          endcase
        end
        if (bus.commit) begin
          step_q[i] <= sh_step_q[i];
          off_q[i]  <= sh_off_q[i];
          amp_q[i]  <= sh_amp_q[i];
          wave_q[i] <= sh_wave_q[i];
        end
        if (bus.sync_clr) begin
          acc_q[i]   <= '0;
          wrap0_q[i] <= 1'b0;
        end else begin
          acc_q[i]   <= acc_d[i];
          wrap0_q[i] <= carry[i];
        end
      end
    end
  end

  // Amp and waveform travel with the sample so a commit never splits one.
  always_ff @(posedge clk) begin
    if (rst) begin
      sine1_q <= '0;
      neg1_q  <= '0;
      out_q   <= '0;
      wrap1_q <= '0;
      wrap2_q <= '0;
      wrap3_q <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        ns1_q[i]  <= '0;
        amp1_q[i] <= '0;
        amp2_q[i] <= '0;
        s2_q[i]   <= '0;
      end
    end else begin
      wrap1_q <= wrap0_q;
      wrap2_q <= wrap1_q;
      wrap3_q <= wrap2_q;
      for (int i = 0; i < NUM_CH; i++) begin
        sine1_q[i] <= (wave_q[i] == 2'd0);
        neg1_q[i]  <= p_s[i][PHASE_W-1];
        ns1_q[i]   <= ns_d[i];
        amp1_q[i]  <= amp_q[i];
        amp2_q[i]  <= amp1_q[i];
        s2_q[i]    <= sine1_q[i] ? (neg1_q[i] ? -$signed({1'b0, lut_dat[i]}) : $signed({1'b0, lut_dat[i]}))
                                 : $signed(ns1_q[i]);
        out_q[i]   <= prod[i][AMP_W +: OUT_W];
      end
    end
  end
endmodule

// File: tb/tb_dds_multichannel.sv
// Directed bench for dds_multichannel: each task configures channels and compares samples to hand-derived values.
module tb_dds_multichannel;
  localparam int NUM_CH = 4, PHASE_W = 32, LUT_W = 10, OUT_W = 14, AMP_W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  dds_multichannel_if #(.NUM_CH(NUM_CH), .PHASE_W(PHASE_W), .OUT_W(OUT_W)) bus ();

  dds_multichannel #(
    .NUM_CH(NUM_CH), .PHASE_W(PHASE_W), .LUT_W(LUT_W), .OUT_W(OUT_W), .AMP_W(AMP_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog got=still_running want=finished");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int ch_out(input int ch);
    return int'($signed(bus.dds_out[ch*OUT_W +: OUT_W]));
  endfunction

  task automatic idle_bus();
    bus.cfg_valid = 1'b0;
    bus.cfg_ch    = '0;
    bus.cfg_addr  = '0;
    bus.cfg_data  = '0;
    bus.commit    = 1'b0;
    bus.sync_clr  = 1'b0;
  endtask

  task automatic do_reset();
    idle_bus();
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
  endtask

  task automatic cfg_write(input int ch, input int addr, input logic [31:0] data);
    int n;
    bus.cfg_valid = 1'b1;
    bus.cfg_ch    = 2'(ch);
    bus.cfg_addr  = 2'(addr);
    bus.cfg_data  = data;
    n = 0;
    while (bus.cfg_ready !== 1'b1 && n < 10) begin
      tick();
      n++;
    end
    checks++;
    if (n >= 10) begin
      failures++;
      $display("FAIL cfg_ready_wait got=%b want=1", bus.cfg_ready);
    end
    tick();
    bus.cfg_valid = 1'b0;
  endtask

  task automatic commit_pulse(input logic sync);
    bus.commit   = 1'b1;
    bus.sync_clr = sync;
    tick();
    bus.commit   = 1'b0;
    bus.sync_clr = 1'b0;
  endtask

  task automatic test_reset();
    idle_bus();
    rst = 1'b1;
    repeat (5) tick();
    checks++;
    if (bus.cfg_ready !== 1'b0) begin failures++; $display("FAIL rst_cfg_ready got=%b want=0", bus.cfg_ready); end
    checks++;
    if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid got=%b want=0", bus.out_valid); end
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (bus.dds_out !== '0 || bus.wrap !== '0 || bus.out_valid !== 1'b0) begin
        failures++;
        $display("FAIL post_rst cyc=%0d got out=%h wrap=%b vld=%b want 0/0/0", k, bus.dds_out, bus.wrap, bus.out_valid);
      end
      if (k == 1) begin
        checks++;
        if (bus.cfg_ready !== 1'b1) begin failures++; $display("FAIL cfg_ready_after_rst got=%b want=1", bus.cfg_ready); end
      end
      tick();
    end
    checks++;
    if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL out_valid_rise got=%b want=1", bus.out_valid); end
    checks++;
    if (bus.dds_out !== '0) begin failures++; $display("FAIL idle_out got=%h want=0", bus.dds_out); end
  endtask

  task automatic test_square();
    int exp;
    logic [3:0] expw;
    do_reset();
    cfg_write(0, 0, 32'h4000_0000);
    cfg_write(0, 3, 32'd1);
    commit_pulse(1'b1);
    repeat (3) tick();
    for (int k = 0; k < 8; k++) begin
      exp  = ((k % 4) < 2) ? 8191 : -8192;
      expw = (k == 4) ? 4'b0001 : 4'b0000;
      checks++;
      if (ch_out(0) !== exp) begin failures++; $display("FAIL square k=%0d got=%0d want=%0d", k, ch_out(0), exp); end
      checks++;
      if (bus.wrap !== expw) begin failures++; $display("FAIL square_wrap k=%0d got=%b want=%b", k, bus.wrap, expw); end
      tick();
    end
  endtask

  task automatic test_saw();
    do_reset();
    cfg_write(1, 0, 32'h0100_0000);
    cfg_write(1, 1, 32'h8000_0000);
    cfg_write(1, 3, 32'd2);
    commit_pulse(1'b1);
    repeat (3) tick();
    for (int k = 0; k < 6; k++) begin
      checks++;
      if (ch_out(1) !== 64 * k) begin failures++; $display("FAIL saw k=%0d got=%0d want=%0d", k, ch_out(1), 64 * k); end
      checks++;
      if (ch_out(0) !== 0 || ch_out(2) !== 0 || ch_out(3) !== 0) begin
        failures++;
        $display("FAIL saw_others k=%0d got=%0d/%0d/%0d want=0/0/0", k, ch_out(0), ch_out(2), ch_out(3));
      end
      tick();
    end
  endtask

  task automatic test_amplitude();
    int exp;
    do_reset();
    cfg_write(0, 0, 32'h4000_0000);
    cfg_write(0, 3, 32'd1);
    cfg_write(0, 2, 32'd128);
    commit_pulse(1'b1);
    repeat (3) tick();
    for (int k = 0; k < 4; k++) begin
      exp = (k < 2) ? 4095 : -4096;
      checks++;
      if (ch_out(0) !== exp) begin failures++; $display("FAIL amp_half k=%0d got=%0d want=%0d", k, ch_out(0), exp); end
      tick();
    end
    cfg_write(0, 2, 32'd300);
    commit_pulse(1'b1);
    repeat (3) tick();
    for (int k = 0; k < 4; k++) begin
      exp = (k < 2) ? 8191 : -8192;
      checks++;
      if (ch_out(0) !== exp) begin failures++; $display("FAIL amp_clamp k=%0d got=%0d want=%0d", k, ch_out(0), exp); end
      tick();
    end
  endtask

  task automatic test_mid_reset();
    rst = 1'b1;
    tick();
    checks++;
    if (bus.dds_out !== '0 || bus.wrap !== '0 || bus.out_valid !== 1'b0 || bus.cfg_ready !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset got out=%h wrap=%b vld=%b rdy=%b want 0/0/0/0", bus.dds_out, bus.wrap, bus.out_valid, bus.cfg_ready);
    end
    rst = 1'b0;
    repeat (4) tick();
    checks++;
    if (ch_out(0) !== 0 || bus.out_valid !== 1'b1) begin
      failures++;
      $display("FAIL mid_reset_cfg got ch0=%0d vld=%b want 0/1", ch_out(0), bus.out_valid);
    end
  endtask

  task automatic test_shadow_commit();
    do_reset();
    cfg_write(2, 0, 32'h0400_0000);
    for (int k = 0; k < 20; k++) begin
      checks++;
      if (ch_out(2) !== 0) begin failures++; $display("FAIL shadow_hold cyc=%0d got=%0d want=0", k, ch_out(2)); end
      tick();
    end
    bus.commit    = 1'b1;
    bus.cfg_valid = 1'b1;
    bus.cfg_ch    = 2'd2;
    bus.cfg_addr  = 2'd3;
    bus.cfg_data  = 32'd1;
    #1;
    checks++;
    if (bus.cfg_ready !== 1'b0) begin failures++; $display("FAIL ready_in_commit got=%b want=0", bus.cfg_ready); end
    @(posedge clk);
    #1;
    bus.commit = 1'b0;
    #1;
    checks++;
    if (bus.cfg_ready !== 1'b1) begin failures++; $display("FAIL ready_after_commit got=%b want=1", bus.cfg_ready); end
    @(posedge clk);
    #1;
    bus.cfg_valid = 1'b0;
    commit_pulse(1'b1);
    repeat (3) tick();
    checks++;
    if (ch_out(2) !== 8191) begin failures++; $display("FAIL held_write k=0 got=%0d want=8191", ch_out(2)); end
    repeat (32) tick();
    checks++;
    if (ch_out(2) !== -8192) begin failures++; $display("FAIL held_write k=32 got=%0d want=-8192", ch_out(2)); end
  endtask

  task automatic test_sine_quadrants();
    int exp_tab [4];
    exp_tab = '{0, 8191, 0, -8191};
    do_reset();
    cfg_write(3, 0, 32'h4000_0000);
    cfg_write(3, 3, 32'd0);
    commit_pulse(1'b1);
    repeat (3) tick();
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (ch_out(3) !== exp_tab[k % 4]) begin
        failures++;
        $display("FAIL sine k=%0d got=%0d want=%0d", k, ch_out(3), exp_tab[k % 4]);
      end
      tick();
    end
  endtask

  task automatic test_triangle();
    int exp_tab [4];
    exp_tab = '{-8192, 0, 8191, -1};
    do_reset();
    cfg_write(2, 0, 32'h4000_0000);
    cfg_write(2, 3, 32'd3);
    commit_pulse(1'b1);
    repeat (3) tick();
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (ch_out(2) !== exp_tab[k]) begin
        failures++;
        $display("FAIL triangle k=%0d got=%0d want=%0d", k, ch_out(2), exp_tab[k]);
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_square();
    test_saw();
    test_amplitude();
    test_mid_reset();
    test_shadow_commit();
    test_sine_quadrants();
    test_triangle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
